ipg_tx_arbiter: RTL and testbench

// - Shares the TX inter-packet-gap (IPG) slot stream between NUM_REQ chunk producers
//   (rreq generator, FakeDRAM reply queue, write-request generator).
// - Grants whole messages atomically (FIRST..LAST never interleaved) using round-robin

---
 rtl/ipg_tx_arbiter_pkg.sv | 32 +++
 rtl/ipg_tx_arbiter_rr_pick.sv | 31 +++
 rtl/ipg_tx_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ipg_tx_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipg_tx_arbiter_pkg.sv
// Shared IPG chunk definitions: block-type encoding, position/class helpers, arbiter states.
// The low byte of each chunk carries {position nibble, class nibble}.
package ipg_tx_arbiter_pkg;

   localparam logic [3:0] BT_POS_FIRST = 4'h0;
   localparam logic [3:0] BT_POS_MID   = 4'h1;
   localparam logic [3:0] BT_POS_LAST  = 4'h2;

   localparam logic [7:0] BT_0A = 8'h0a;
   localparam logic [7:0] BT_1A = 8'h1a;
   localparam logic [7:0] BT_2A = 8'h2a;
   localparam logic [7:0] BT_0B = 8'h0b;
   localparam logic [7:0] BT_1B = 8'h1b;
   localparam logic [7:0] BT_2B = 8'h2b;
   localparam logic [7:0] BT_0C = 8'h0c;
   localparam logic [7:0] BT_1C = 8'h1c;
   localparam logic [7:0] BT_2C = 8'h2c;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } arb_state_t;

   function automatic logic [3:0] bt_pos(input logic [7:0] bt);
      return bt[7:4];
   endfunction

   function automatic logic [3:0] bt_class(input logic [7:0] bt);
      return bt[3:0];
   endfunction

endpackage

// File: rtl/ipg_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: searches from i_last+1 (wrapping) for the first
// requesting index and returns it both as a one-hot vector and as an index.
module ipg_tx_arbiter_rr_pick #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_last,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   logic [IW-1:0] w_c;

   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_c   = '0;
      for (int off = 1; off <= N; off++) begin
         w_c = IW'((int'(i_last) + off) % N);
         if (!o_any && i_req[w_c]) begin
            o_any      = 1'b1;
            o_gnt[w_c] = 1'b1;
            o_idx      = w_c;
         end
      end
   end

endmodule

// File: rtl/ipg_tx_arbiter.sv
// Message-atomic round-robin arbiter feeding one chunk per free IPG slot to the PCS,
// with malformed-head discard and abort-with-terminator for stalled owners.
module ipg_tx_arbiter
   import ipg_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 64,
   parameter int MAX_STALL  = 16,
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          i_clk,
   input  logic                          i_reset_n,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_chunk,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   output logic [NUM_REQ-1:0]            o_req_ready,
   input  logic                          i_ipg_slot,
   output logic [DATA_WIDTH-1:0]         o_tx_ipg_data,
   output logic                          o_tx_ipg_valid,
   output logic [GW-1:0]                 o_grant_id,
   output logic                          o_busy,
   output logic                          o_err_type,
   output logic                          o_err_stall
);

   localparam int SW = $clog2(MAX_STALL + 1);

   arb_state_t              r_state, w_state_n;
   logic [GW-1:0]           r_grant_id, w_grant_n;
   logic [SW-1:0]           r_stall, w_stall_n;
   logic [3:0]              r_class, w_class_n;
   logic [DATA_WIDTH-1:0]   r_tx_data, w_tx_data_n;
   logic                    r_tx_valid, w_tx_valid_n;
   logic                    r_err_type, w_err_type_n;
   logic                    r_err_stall, w_err_stall_n;

   logic [NUM_REQ-1:0]      w_first, w_bad, w_bad_oh, w_ready;
   logic [NUM_REQ-1:0]      w_pick_gnt;
   logic [GW-1:0]           w_pick_idx;
   logic                    w_pick_any;
   logic [DATA_WIDTH-1:0]   w_pick_chunk, w_own_chunk;
   logic                    w_own_valid;
   logic [3:0]              w_own_pos;

   always_comb begin
      w_first      = '0;
      w_bad        = '0;
      w_pick_chunk = '0;
      w_own_chunk  = '0;
      w_own_valid  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_first[i] = i_req_valid[i] &&
                      (bt_pos(i_req_chunk[i*DATA_WIDTH +: 8]) == BT_POS_FIRST);
         w_bad[i]   = i_req_valid[i] &&
                      (bt_pos(i_req_chunk[i*DATA_WIDTH +: 8]) != BT_POS_FIRST);
         if (w_pick_gnt[i])
            w_pick_chunk = i_req_chunk[i*DATA_WIDTH +: DATA_WIDTH];
         if (GW'(i) == r_grant_id) begin
            w_own_chunk = i_req_chunk[i*DATA_WIDTH +: DATA_WIDTH];
            w_own_valid = i_req_valid[i];
         end
      end
   end

   // Lowest-index malformed head is the one discarded this cycle.
   assign w_bad_oh  = w_bad & (~w_bad + NUM_REQ'(1));
   assign w_own_pos = bt_pos(w_own_chunk[7:0]);

   ipg_tx_arbiter_rr_pick #(.N(NUM_REQ), .IW(GW)) u_rr_pick (
      .i_req  (w_first),
      .i_last (r_grant_id),
      .o_gnt  (w_pick_gnt),
      .o_idx  (w_pick_idx),
      .o_any  (w_pick_any)
   );

   always_comb begin
      w_state_n     = r_state;
      w_grant_n     = r_grant_id;
      w_stall_n     = r_stall;
      w_class_n     = r_class;
      w_tx_data_n   = r_tx_data;
      w_tx_valid_n  = 1'b0;
      w_err_type_n  = 1'b0;
      w_err_stall_n = 1'b0;
      w_ready       = '0;
      case (r_state)
         ST_IDLE: begin
            if (|w_bad) begin
               w_ready      = w_bad_oh;
               w_err_type_n = 1'b1;
            end else if (i_ipg_slot && w_pick_any) begin
               w_ready      = w_pick_gnt;
               w_tx_data_n  = w_pick_chunk;
               w_tx_valid_n = 1'b1;
               w_grant_n    = w_pick_idx;
               w_stall_n    = '0;
               w_class_n    = bt_class(w_pick_chunk[7:0]);
               w_state_n    = ST_LOCK;
            end
         end
         ST_LOCK: begin
            if (i_ipg_slot && w_own_valid) begin
               for (int i = 0; i < NUM_REQ; i++)
                  w_ready[i] = (GW'(i) == r_grant_id);
               w_tx_data_n  = w_own_chunk;
               w_tx_valid_n = 1'b1;
               w_stall_n    = '0;
               if (w_own_pos == BT_POS_LAST)
                  w_state_n = ST_IDLE;
               else if (w_own_pos != BT_POS_MID)
                  w_err_type_n = 1'b1;
            end else if (i_ipg_slot) begin
               if (r_stall >= SW'(MAX_STALL - 1)) begin
                  // Close the aborted message so the PCS never sees a dangling FIRST.
                  w_tx_data_n   = {{(DATA_WIDTH-8){1'b1}}, BT_POS_LAST, r_class};
                  w_tx_valid_n  = 1'b1;
                  w_err_stall_n = 1'b1;
                  w_stall_n     = SW'(MAX_STALL);
                  w_state_n     = ST_IDLE;
               end else begin
                  w_stall_n = r_stall + SW'(1);
               end
            end
         end
         default: w_state_n = ST_IDLE;
      endcase
   end

   assign o_req_ready = w_ready & {NUM_REQ{i_reset_n}};

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state     <= ST_IDLE;
         r_grant_id  <= GW'(NUM_REQ - 1);
         r_stall     <= '0;
         r_class     <= '0;
         r_tx_data   <= '0;
         r_tx_valid  <= 1'b0;
         r_err_type  <= 1'b0;
         r_err_stall <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_grant_id  <= w_grant_n;
         r_stall     <= w_stall_n;
         r_class     <= w_class_n;
         r_tx_data   <= w_tx_data_n;
         r_tx_valid  <= w_tx_valid_n;
         r_err_type  <= w_err_type_n;
         r_err_stall <= w_err_stall_n;
      end
   end

   assign o_tx_ipg_data  = r_tx_data;
   assign o_tx_ipg_valid = r_tx_valid;
   assign o_grant_id     = r_grant_id;
   assign o_busy         = (r_state == ST_LOCK);
   assign o_err_type     = r_err_type;
   assign o_err_stall    = r_err_stall;

endmodule

// File: tb/tb_ipg_tx_arbiter.sv
// Scoreboard bench for ipg_tx_arbiter: per-requester chunk queues feed the DUT, expected
// TX chunks are queued as stimulus is written and popped whenever tx_ipg_valid appears.
module tb_ipg_tx_arbiter;
   import ipg_tx_arbiter_pkg::*;

   localparam int N  = 3;
   localparam int DW = 64;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [N*DW-1:0] req_chunk = '0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic            ipg_slot = 1'b0;
   logic [DW-1:0]   tx_data;
   logic            tx_valid;
   logic [1:0]      grant_id;
   logic            busy;
   logic            err_type;
   logic            err_stall;

   int errors = 0;
   int checks = 0;
   int n_et = 0;
   int n_es = 0;
   int n_tx = 0;

   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   logic [DW-1:0] q2[$];
   logic [DW-1:0] exp_q[$];

   ipg_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_STALL(16)) dut (
      .i_clk          (clk),
      .i_reset_n      (reset_n),
      .i_req_chunk    (req_chunk),
      .i_req_valid    (req_valid),
      .o_req_ready    (req_ready),
      .i_ipg_slot     (ipg_slot),
      .o_tx_ipg_data  (tx_data),
      .o_tx_ipg_valid (tx_valid),
      .o_grant_id     (grant_id),
      .o_busy         (busy),
      .o_err_type     (err_type),
      .o_err_stall    (err_stall)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mk(input logic [55:0] pl, input logic [7:0] bt);
      return {pl, bt};
   endfunction

   // Push a chunk to a requester; fwd=1 also queues it as expected TX output.
   task automatic put(input int r, input logic [DW-1:0] c, input bit fwd);
      case (r)
         0: q0.push_back(c);
         1: q1.push_back(c);
         default: q2.push_back(c);
      endcase
      if (fwd) exp_q.push_back(c);
   endtask

   task automatic step(input logic slot);
      logic [N-1:0]  xfer;
      logic [DW-1:0] e;
      @(negedge clk);
      ipg_slot = slot;
      req_valid[0] = (q0.size() > 0);
      req_valid[1] = (q1.size() > 0);
      req_valid[2] = (q2.size() > 0);
      req_chunk[0*DW +: DW] = (q0.size() > 0) ? q0[0] : '0;
      req_chunk[1*DW +: DW] = (q1.size() > 0) ? q1[0] : '0;
      req_chunk[2*DW +: DW] = (q2.size() > 0) ? q2[0] : '0;
      #3;
      xfer = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (xfer[0]) void'(q0.pop_front());
      if (xfer[1]) void'(q1.pop_front());
      if (xfer[2]) void'(q2.pop_front());
      if (tx_valid === 1'b1) begin
         n_tx++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL tx_unexpected: got %h, nothing expected", tx_data);
         end else begin
            e = exp_q.pop_front();
            if (tx_data !== e) begin
               errors++;
               $display("FAIL tx_data: got %h, expected %h", tx_data, e);
            end
         end
      end
      if (err_type === 1'b1) n_et++;
      if (err_stall === 1'b1) n_es++;
   endtask

   task automatic drain(input string name, input int budget);
      int k;
      k = 0;
      while (exp_q.size() > 0 && k < budget) begin
         step(1'b1);
         k++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d chunks still expected after %0d slots",
                  name, exp_q.size(), budget);
         exp_q.delete();
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step(1'b0);
      step(1'b0);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks += 6;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, expected 0", tx_valid); end
      if (tx_data !== '0)    begin errors++; $display("FAIL rst_data: got %h, expected 0", tx_data); end
      if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
      if (grant_id !== 2'd2) begin errors++; $display("FAIL rst_grant: got %0d, expected 2", grant_id); end
      if (err_type !== 1'b0) begin errors++; $display("FAIL rst_err_type: got %b, expected 0", err_type); end
      if (err_stall !== 1'b0) begin errors++; $display("FAIL rst_err_stall: got %b, expected 0", err_stall); end
   endtask

   task automatic test_single();
      logic [2:0] b;
      int tx0;
      tx0 = n_tx;
      put(0, mk(56'h11, BT_0A), 1);
      put(0, mk(56'h12, BT_1A), 1);
      put(0, mk(56'h13, BT_2A), 1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1);
         b[i] = busy;
      end
      checks += 3;
      if (b !== 3'b011) begin errors++; $display("FAIL single_busy: got %b, expected 011", b); end
      if (grant_id !== 2'd0) begin errors++; $display("FAIL single_grant: got %0d, expected 0", grant_id); end
      if (n_tx - tx0 != 3) begin errors++; $display("FAIL single_count: got %0d, expected 3", n_tx - tx0); end
      drain("single", 4);
   endtask

   task automatic test_back_to_back();
      int tx0;
      do_reset();
      tx0 = n_tx;
      put(0, mk(56'h21, BT_0A), 1);
      put(0, mk(56'h22, BT_1A), 1);
      put(0, mk(56'h23, BT_2A), 1);
      put(1, mk(56'h31, BT_0B), 0);
      put(1, mk(56'h32, BT_1B), 0);
      put(1, mk(56'h33, BT_2B), 0);
      exp_q.push_back(mk(56'h31, BT_0B));
      exp_q.push_back(mk(56'h32, BT_1B));
      exp_q.push_back(mk(56'h33, BT_2B));
      for (int i = 0; i < 6; i++) step(1'b1);
      checks += 2;
      if (n_tx - tx0 != 6) begin errors++; $display("FAIL b2b_count: got %0d, expected 6", n_tx - tx0); end
      if (grant_id !== 2'd1) begin errors++; $display("FAIL b2b_grant: got %0d, expected 1", grant_id); end
      drain("b2b", 4);
      put(0, mk(56'h41, BT_0A), 0);
      put(0, mk(56'h42, BT_2A), 0);
      put(2, mk(56'h51, BT_0C), 1);
      put(2, mk(56'h52, BT_2C), 1);
      exp_q.push_back(mk(56'h41, BT_0A));
      exp_q.push_back(mk(56'h42, BT_2A));
      step(1'b1);
      checks++;
      if (grant_id !== 2'd2) begin errors++; $display("FAIL rr_grant: got %0d, expected 2", grant_id); end
      drain("rr", 8);
   endtask

   task automatic test_slot_gating();
      int bad_low;
      bad_low = 0;
      put(1, mk(56'h61, BT_0B), 1);
      put(1, mk(56'h62, BT_1B), 1);
      put(1, mk(56'h63, BT_1B), 1);
      put(1, mk(56'h64, BT_2B), 1);
      step(1'b1);
      put(2, mk(56'h71, BT_0C), 1);
      put(2, mk(56'h72, BT_2C), 1);
      for (int i = 0; i < 6; i++) begin
         step(i[0]);
         if (!i[0] && tx_valid !== 1'b0) bad_low++;
      end
      checks += 2;
      if (bad_low != 0) begin errors++; $display("FAIL gate_low_slot: got %0d valid in low slots, expected 0", bad_low); end
      if (exp_q.size() != 2) begin errors++; $display("FAIL gate_pending: got %0d pending, expected 2", exp_q.size()); end
      drain("gate", 6);
   endtask

   task automatic test_drop();
      int et0, tx0;
      et0 = n_et;
      tx0 = n_tx;
      put(1, mk(56'h81, BT_1B), 0);
      step(1'b0);
      checks += 3;
      if (n_et - et0 != 1) begin errors++; $display("FAIL drop_err: got %0d pulses, expected 1", n_et - et0); end
      if (q1.size() != 0) begin errors++; $display("FAIL drop_ready: got %0d left, expected 0", q1.size()); end
      if (n_tx != tx0) begin errors++; $display("FAIL drop_tx: got %0d tx, expected 0", n_tx - tx0); end
      put(0, mk(56'h91, BT_2A), 0);
      put(2, mk(56'h92, BT_0C), 1);
      put(2, mk(56'h93, BT_2C), 1);
      step(1'b1);
      checks += 2;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL drop_prec: got valid %b, expected 0", tx_valid); end
      if (n_et - et0 != 2) begin errors++; $display("FAIL drop_err2: got %0d pulses, expected 2", n_et - et0); end
      drain("drop", 4);
   endtask

   task automatic test_stall();
      int es0;
      es0 = n_es;
      put(0, mk(56'ha1, BT_0C), 1);
      step(1'b1);
      for (int i = 0; i < 15; i++) begin
         step(1'b1);
         if (i == 4) begin
            step(1'b0);
            step(1'b0);
         end
      end
      checks += 3;
      if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy15: got %b, expected 1", busy); end
      if (n_es != es0) begin errors++; $display("FAIL stall_early: got %0d pulses, expected 0", n_es - es0); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL stall_first: got %0d pending, expected 0", exp_q.size()); end
      exp_q.push_back(64'hFFFFFFFFFFFFFF2c);
      step(1'b1);
      checks += 3;
      if (n_es - es0 != 1) begin errors++; $display("FAIL stall_pulse: got %0d pulses, expected 1", n_es - es0); end
      if (busy !== 1'b0) begin errors++; $display("FAIL stall_idle: got %b, expected 0", busy); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL stall_term: got %0d pending, expected 0", exp_q.size()); end
      exp_q.delete();
      put(1, mk(56'hb1, BT_0B), 1);
      put(1, mk(56'hb2, BT_2B), 1);
      drain("stall_next", 4);
      checks++;
      if (grant_id !== 2'd1) begin errors++; $display("FAIL stall_regrant: got %0d, expected 1", grant_id); end
   endtask

   task automatic test_reset_mid();
      int et0;
      put(0, mk(56'hc1, BT_0A), 1);
      put(0, mk(56'hc2, BT_1A), 1);
      put(0, mk(56'hc3, BT_1A), 0);
      put(0, mk(56'hc4, BT_2A), 0);
      step(1'b1);
      step(1'b1);
      reset_n = 1'b0;
      step(1'b1);
      checks += 5;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b, expected 0", tx_valid); end
      if (tx_data !== '0) begin errors++; $display("FAIL rmid_data: got %h, expected 0", tx_data); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b, expected 0", busy); end
      if (grant_id !== 2'd2) begin errors++; $display("FAIL rmid_grant: got %0d, expected 2", grant_id); end
      if (q0.size() != 2) begin errors++; $display("FAIL rmid_hold: got %0d left, expected 2", q0.size()); end
      reset_n = 1'b1;
      et0 = n_et;
      for (int i = 0; i < 4; i++) step(1'b1);
      checks += 3;
      if (n_et - et0 != 2) begin errors++; $display("FAIL rmid_drop: got %0d pulses, expected 2", n_et - et0); end
      if (q0.size() != 0) begin errors++; $display("FAIL rmid_empty: got %0d left, expected 0", q0.size()); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_pending: got %0d pending, expected 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_slot_gating();
      test_drop();
      test_stall();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
